sink_byte_serializer: RTL and testbench
=======================================

# sink_byte_serializer

Sits directly downstream of the network sink stage. Takes one `SNK_WIDTH`-bit output word per valid/ready handshake and emits it as a sequence of bytes on a byte-stream handshake toward the host transmitter (UART/FIFO TX). Words are sent least-significant byte first. The block sustains full byte throughput, with no bubble between consecutive words.

## Interface
Parameters:
- `SNK_WIDTH`, default `sink_config::SNK_WIDTH`: width of the network output word; must be ≥ 1.
- `BYTE_WIDTH`, fixed 8: width of the transmit symbol; not overridable.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `arstn`, in, 1: asynchronous, active-low reset.
- `snk_valid`, in, 1: the upstream sink word is valid.
- `snk_ready`, out, 1: the block accepts `snk` this cycle.
- `snk`, in, `SNK_WIDTH`: network output word.
- `tx_ready`, in, 1: the transmitter accepts `tx_data` this cycle.
- `tx_valid`, out, 1: `tx_data` holds a byte to transmit.
- `tx_data`, out, 8: current byte.

## Operation
- `SNK_NUM_BYTES = ceil(SNK_WIDTH/8)`.
- Word acceptance is `snk_valid && snk_ready`. Byte transfer is `tx_valid && tx_ready`.
- State machine has two states, IDLE and SEND.
- IDLE:
  - Outputs: `snk_ready=1`, `tx_valid=0`.
  - On word acceptance: load `shreg` (`SNK_NUM_BYTES*8` bits) with `snk` zero-extended, load `remain = SNK_NUM_BYTES`, go to SEND.
- SEND:
  - Outputs: `tx_valid=1`, `tx_data = shreg[7:0]`.
  - On byte transfer with `remain > 1`: shift `shreg` right by 8 (zero fill) and decrement `remain`.
  - On byte transfer with `remain == 1` (last byte):
    - If a word is accepted in the same cycle, reload `shreg`/`remain` and stay in SEND.
    - Otherwise go to IDLE.
- `snk_ready = (state==IDLE) || (state==SEND && remain==1 && tx_ready)`. This is a combinational path from `tx_ready` to `snk_ready`; it is the only one.
- `tx_valid`, once high, stays high until the byte transfer completes, and `tx_data` stays stable while `tx_valid && !tx_ready` (AXI-stream rules).
- Unused high bits of the final byte (when `SNK_WIDTH % 8 != 0`) are 0.
- `SNK_WIDTH ≤ 8`:
  - `SNK_NUM_BYTES = 1` and `remain` is 1 bit wide.
  - Every byte is the last byte.
- Counter width is `$clog2(SNK_NUM_BYTES+1)`. `remain` never wraps: it is reloaded only at word acceptance and never decremented below 1.
- No frame delimiter is generated. The host frames by count (`SNK_NUM_BYTES`).

## Timing
- Reset values:
  - State IDLE.
  - `tx_valid=0`, `tx_data=0` (`shreg` cleared), `remain=0`.
  - `snk_ready=1` (reflects IDLE). Handshakes while `arstn` is low are discarded.
- Reset asserted mid-word: the partially sent word is dropped. After release the block is in IDLE and the next byte sent is byte 0 of a new word.
- Latency: a word accepted in cycle N gives `tx_valid=1` with byte 0 in cycle N+1.
- With `tx_ready` held high, byte k transfers in cycle N+1+k. The next word can be accepted in cycle N+`SNK_NUM_BYTES`, which gives one byte per cycle continuously.
- `tx_ready` low stalls the block indefinitely with no loss. `snk_ready` stays low in SEND until the last-byte transfer.

## Structure
- Add `localparam int SNK_NUM_BYTES = (SNK_WIDTH+7)/8;` to package `sink_config`.
- Define `typedef enum logic {IDLE, SEND} ser_state_t;` locally in the module.
- A single flat module; no sub-module is needed.

## Test plan
- `SNK_WIDTH=12`, `snk=12'hABC`, `tx_ready=1` → `tx_data` is 0xBC in cycle N+1 and 0x0A in cycle N+2. `snk_ready` is 0 in cycle N+1 and 1 in cycle N+2.
- `SNK_WIDTH=24`, words 0x123456 and 0x789ABC presented back-to-back with `tx_ready=1` → `tx_valid` is high for 6 consecutive cycles with bytes 56,34,12,BC,9A,78, no bubble.
- `SNK_WIDTH=16`, `snk=16'hBEEF`, `tx_ready` toggling 0,0,1,0,1 → 0xEF is held stable until the first accept, then 0xBE. No duplicate or dropped byte.
- `SNK_WIDTH=4`, `snk=4'h5` → a single byte 0x05, and the block returns to IDLE one cycle later.
- `SNK_WIDTH=24`, `arstn` pulsed low after byte 0 is sent → `tx_valid=0` immediately. After release, a new word 0x000001 sends 01,00,00.
- Randomized `snk_valid`/`tx_ready` over 1000 words → the scoreboard's reassembled words match the inputs exactly.

Source files
------------

// File: rtl/sink_byte_serializer_pkg.sv
// Shared sink-side sizing: the network output word width and the number of bytes it occupies on the wire.
package sink_config;
    localparam int SNK_WIDTH     = 24;
    localparam int SNK_NUM_BYTES = (SNK_WIDTH + 7) / 8;
endpackage

// File: rtl/sink_byte_serializer.sv
// Serializes one SNK_WIDTH word into LSB-first bytes; byte 0 is presented the cycle after the word is accepted.
// tx_ready low stalls without loss; snk_ready rises combinationally with the last-byte transfer so words stream with no bubble.
module sink_byte_serializer #(
    parameter int SNK_WIDTH = sink_config::SNK_WIDTH
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 snk_valid,
    output logic                 snk_ready,
    input  logic [SNK_WIDTH-1:0] snk,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data
);
    localparam int BYTE_WIDTH = 8;
    localparam int NUM_BYTES  = (SNK_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int SHW        = NUM_BYTES * BYTE_WIDTH;
    localparam int CW         = $clog2(NUM_BYTES + 1);

    typedef enum logic {IDLE, SEND} ser_state_t;

    ser_state_t        state_q, state_d;
    logic [SHW-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]     remain_q, remain_d;
    logic              last_byte;

    assign last_byte = (remain_q == CW'(1));
    assign tx_data   = shreg_q[BYTE_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        remain_d  = remain_q;
        snk_ready = 1'b0;
        tx_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                snk_ready = 1'b1;
                if (snk_valid) begin
                    shreg_d  = SHW'(snk);
                    remain_d = CW'(NUM_BYTES);
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_valid  = 1'b1;
                snk_ready = last_byte && tx_ready;
                if (tx_ready) begin
                    if (!last_byte) begin
                        shreg_d  = shreg_q >> BYTE_WIDTH;
                        remain_d = remain_q - CW'(1);
                    end else if (snk_valid) begin
                        // Back-to-back reload keeps the byte stream gap-free.
                        shreg_d  = SHW'(snk);
                        remain_d = CW'(NUM_BYTES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            remain_q <= remain_d;
        end
    end
endmodule

// File: tb/tb_sink_byte_serializer.sv
// Directed and randomized checks of the byte serializer at widths 24 (default), 12, 16 and 4.
module tb_sink_byte_serializer;
    logic clk;
    logic arstn;

    logic        v24, r24, tr24, tv24;
    logic [23:0] s24;
    logic [7:0]  d24;
    logic        v12, r12, tr12, tv12;
    logic [11:0] s12;
    logic [7:0]  d12;
    logic        v16, r16, tr16, tv16;
    logic [15:0] s16;
    logic [7:0]  d16;
    logic        v4, r4, tr4, tv4;
    logic [3:0]  s4;
    logic [7:0]  d4;

    int npass = 0;
    int nchk  = 0;
    int nfail = 0;

    sink_byte_serializer u24 (.clk(clk), .arstn(arstn), .snk_valid(v24), .snk_ready(r24), .snk(s24),
                              .tx_ready(tr24), .tx_valid(tv24), .tx_data(d24));
    sink_byte_serializer #(.SNK_WIDTH(12)) u12 (.clk(clk), .arstn(arstn), .snk_valid(v12), .snk_ready(r12), .snk(s12),
                              .tx_ready(tr12), .tx_valid(tv12), .tx_data(d12));
    sink_byte_serializer #(.SNK_WIDTH(16)) u16 (.clk(clk), .arstn(arstn), .snk_valid(v16), .snk_ready(r16), .snk(s16),
                              .tx_ready(tr16), .tx_valid(tv16), .tx_data(d16));
    sink_byte_serializer #(.SNK_WIDTH(4)) u4 (.clk(clk), .arstn(arstn), .snk_valid(v4), .snk_ready(r4), .snk(s4),
                              .tx_ready(tr4), .tx_valid(tv4), .tx_data(d4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference: each accepted word becomes NB bytes, LSB first; reassembled words must equal inputs in order.
    logic [23:0] word_q[$];
    logic [23:0] asm_word;
    int          asm_cnt;
    int          words_in;
    int          words_out;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        acc, xfer;
    logic [7:0]  exp24 [6];
    logic [7:0]  exp_rst [3];

    initial begin
        arstn = 1'b0;
        {v24, tr24, v12, tr12, v16, tr16, v4, tr4} = '0;
        s24 = '0; s12 = '0; s16 = '0; s4 = '0;
        step();
        settle();
        chk("rst_tx_valid", 32'(tv24), 32'd0);
        chk("rst_tx_data", 32'(d24), 32'd0);
        chk("rst_snk_ready", 32'(r24), 32'd1);
        step();
        arstn = 1'b1;
        step();

        // Width 12: 0xABC -> BC then 0A
        v12 = 1'b1; s12 = 12'hABC; tr12 = 1'b1;
        settle();
        chk("w12_idle_ready", 32'(r12), 32'd1);
        step();
        v12 = 1'b0;
        settle();
        chk("w12_b0_valid", 32'(tv12), 32'd1);
        chk("w12_b0_data", 32'(d12), 32'hBC);
        chk("w12_b0_snk_ready", 32'(r12), 32'd0);
        step();
        settle();
        chk("w12_b1_data", 32'(d12), 32'h0A);
        chk("w12_b1_snk_ready", 32'(r12), 32'd1);
        step();
        settle();
        chk("w12_idle_after", 32'(tv12), 32'd0);

        // Width 24: two words back to back, six bytes with no bubble
        exp24[0] = 8'h56; exp24[1] = 8'h34; exp24[2] = 8'h12;
        exp24[3] = 8'hBC; exp24[4] = 8'h9A; exp24[5] = 8'h78;
        v24 = 1'b1; s24 = 24'h123456; tr24 = 1'b1;
        step();
        s24 = 24'h789ABC;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) v24 = 1'b0;
            settle();
            chk($sformatf("w24_b2b_valid%0d", i), 32'(tv24), 32'd1);
            chk($sformatf("w24_b2b_data%0d", i), 32'(d24), 32'(exp24[i]));
            if (i == 2) chk("w24_b2b_reload_ready", 32'(r24), 32'd1);
            step();
        end
        settle();
        chk("w24_b2b_done", 32'(tv24), 32'd0);
        tr24 = 1'b0;

        // Width 16: stalls hold EF stable, then BE
        v16 = 1'b1; s16 = 16'hBEEF; tr16 = 1'b0;
        step();
        v16 = 1'b0;
        tr16 = 1'b0; settle();
        chk("w16_stall0", 32'(d16), 32'hEF);
        step();
        tr16 = 1'b0; settle();
        chk("w16_stall1", 32'(d16), 32'hEF);
        chk("w16_stall1_valid", 32'(tv16), 32'd1);
        step();
        tr16 = 1'b1; settle();
        chk("w16_acc0", 32'(d16), 32'hEF);
        step();
        tr16 = 1'b0; settle();
        chk("w16_stall2", 32'(d16), 32'hBE);
        chk("w16_stall2_snk_ready", 32'(r16), 32'd0);
        step();
        tr16 = 1'b1; settle();
        chk("w16_acc1", 32'(d16), 32'hBE);
        chk("w16_acc1_snk_ready", 32'(r16), 32'd1);
        step();
        tr16 = 1'b0; settle();
        chk("w16_done", 32'(tv16), 32'd0);

        // Width 4: single zero-padded byte
        v4 = 1'b1; s4 = 4'h5; tr4 = 1'b1;
        step();
        v4 = 1'b0;
        settle();
        chk("w4_valid", 32'(tv4), 32'd1);
        chk("w4_data", 32'(d4), 32'h05);
        chk("w4_last_ready", 32'(r4), 32'd1);
        step();
        settle();
        chk("w4_idle", 32'(tv4), 32'd0);

        // Width 24: reset mid-word drops the rest
        v24 = 1'b1; s24 = 24'hABCDEF; tr24 = 1'b1;
        step();
        v24 = 1'b0;
        settle();
        chk("rst_mid_b0", 32'(d24), 32'hEF);
        step();
        settle();
        chk("rst_mid_b1", 32'(d24), 32'hCD);
        arstn = 1'b0;
        settle();
        chk("rst_mid_valid", 32'(tv24), 32'd0);
        chk("rst_mid_data", 32'(d24), 32'd0);
        step();
        arstn = 1'b1;
        step();
        exp_rst[0] = 8'h01; exp_rst[1] = 8'h00; exp_rst[2] = 8'h00;
        v24 = 1'b1; s24 = 24'h000001;
        step();
        v24 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("rst_new_valid%0d", i), 32'(tv24), 32'd1);
            chk($sformatf("rst_new_data%0d", i), 32'(d24), 32'(exp_rst[i]));
            step();
        end
        settle();
        chk("rst_new_done", 32'(tv24), 32'd0);

        // Randomized traffic on width 24
        asm_word = '0; asm_cnt = 0; words_in = 0; words_out = 0;
        prev_stall = 1'b0; prev_data = '0;
        v24 = 1'b0;
        for (int cyc = 0; cyc < 20000 && !(words_in == 1000 && word_q.size() == 0); cyc++) begin
            if (!v24 && words_in < 1000 && ($urandom_range(0, 3) != 0)) begin
                v24 = 1'b1;
                s24 = 24'($urandom);
            end
            tr24 = (words_in == 1000) ? 1'b1 : ($urandom_range(0, 9) < 7);
            settle();
            if (prev_stall) begin
                chk("rand_hold_valid", 32'(tv24), 32'd1);
                chk("rand_hold_data", 32'(d24), 32'(prev_data));
            end
            acc  = v24 && r24;
            xfer = tv24 && tr24;
            prev_stall = tv24 && !tr24;
            prev_data  = d24;
            if (acc) begin
                word_q.push_back(s24);
                words_in++;
            end
            if (xfer) begin
                asm_word = asm_word | (24'(d24) << (8 * asm_cnt));
                asm_cnt++;
                if (asm_cnt == 3) begin
                    if (word_q.size() == 0) begin
                        chk("rand_spurious_word", 32'(asm_word), 32'hFFFFFFFF);
                    end else begin
                        chk($sformatf("rand_word%0d", words_out), 32'(asm_word), 32'(word_q.pop_front()));
                    end
                    words_out++;
                    asm_word = '0;
                    asm_cnt  = 0;
                end
            end
            step();
            if (acc) v24 = 1'b0;
        end
        chk("rand_words_in", 32'(words_in), 32'd1000);
        chk("rand_words_out", 32'(words_out), 32'd1000);
        chk("rand_partial", 32'(asm_cnt), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
